// File: rtl/uart_tx_mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter.
// Register offsets, STATUS bit positions and TX FSM encoding.
package uart_tx_mmio_pkg;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_ACTIVE = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_LVL_LO = 4;
    localparam int ST_LVL_HI = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_tx_fifo.sv
// Synchronous show-ahead FIFO feeding the UART transmitter.
// A push into a full FIFO is still taken when a pop happens on the same edge.
module uart_tx_mmio_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             w_pop;
    logic             w_push;

    assign full   = (r_level == LW'(DEPTH));
    assign empty  = (r_level == '0);
    assign level  = r_level;
    assign dout   = r_mem[r_rptr];
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: pointers decide what is valid
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Bus decode, STATUS register, baud counter and TX shift FSM.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 1_000_000,
    parameter int BAUD        = 115_200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        io_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        TXD,
    output logic        tx_busy
);

    localparam int DIV = CLK_FREQ_HZ / BAUD;
    localparam int BW  = $clog2(DIV);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;

    tx_state_e     r_state, w_state_nx;
    logic [BW-1:0] r_baud, w_baud_nx;
    logic [2:0]    r_bit, w_bit_nx;
    logic [7:0]    r_shift, w_shift_nx;
    logic          r_txd, w_txd_nx;
    logic          r_busy;
    logic          r_ovf;
    logic [31:0]   r_rdata;

    logic [1:0]    w_off;
    logic          w_wr_tx, w_rd, w_rd_status;
    logic          w_push_ok, w_ovf_evt, w_pop, w_last;
    logic          w_full, w_empty;
    logic [7:0]    w_dout;
    logic [LW-1:0] w_level, w_lvl_nx;
    logic [31:0]   w_status;
    logic          w_unused;

    assign w_off       = mem_addr[3:2];
    assign w_wr_tx     = io_sel && (w_off == UART_TXDATA) && mem_wmask[0];
    assign w_rd        = io_sel && mem_rstrb;
    assign w_rd_status = w_rd && (w_off == UART_STATUS);
    assign w_push_ok   = w_wr_tx && (!w_full || w_pop);
    assign w_ovf_evt   = w_wr_tx && !w_push_ok;
    assign w_last      = (r_baud == BW'(DIV - 1));
    assign w_lvl_nx    = w_level + LW'(w_push_ok) - LW'(w_pop);
    assign w_unused    = ^{mem_addr[31:4], mem_addr[1:0],
                           mem_wdata[31:8], mem_wmask[3:1]};

    assign mem_rdata = r_rdata;
    assign TXD       = r_txd;
    assign tx_busy   = r_busy;

    uart_tx_mmio_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_wr_tx),
        .pop    (w_pop),
        .din    (mem_wdata[7:0]),
        .dout   (w_dout),
        .full   (w_full),
        .empty  (w_empty),
        .level  (w_level)
    );

    always_comb begin
        w_status                      = '0;
        w_status[ST_FULL]             = w_full;
        w_status[ST_EMPTY]            = w_empty;
        w_status[ST_ACTIVE]           = (r_state != S_IDLE);
        w_status[ST_OVF]              = r_ovf;
        w_status[ST_LVL_HI:ST_LVL_LO] = 5'(w_level);
    end

    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_txd_nx   = r_txd;
        w_pop      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_txd_nx  = 1'b1;
                w_baud_nx = '0;
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = w_dout;
                    w_txd_nx   = 1'b0;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (w_last) begin
                    w_baud_nx  = '0;
                    w_bit_nx   = '0;
                    w_txd_nx   = r_shift[0];
                    w_state_nx = S_DATA;
                end else begin
                    w_baud_nx = r_baud + BW'(1);
                end
            end
            S_DATA: begin
                if (w_last) begin
                    w_baud_nx = '0;
                    if (r_bit == 3'd7) begin
                        w_txd_nx   = 1'b1;
                        w_state_nx = S_STOP;
                    end else begin
                        w_bit_nx   = r_bit + 3'd1;
                        w_shift_nx = {1'b0, r_shift[7:1]};
                        w_txd_nx   = r_shift[1];
                    end
                end else begin
                    w_baud_nx = r_baud + BW'(1);
                end
            end
            S_STOP: begin
                if (w_last) begin
                    w_baud_nx = '0;
                    // Chain straight into the next start bit when data waits
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_shift_nx = w_dout;
                        w_txd_nx   = 1'b0;
                        w_state_nx = S_START;
                    end else begin
                        w_txd_nx   = 1'b1;
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_baud_nx = r_baud + BW'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_baud  <= w_baud_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_txd   <= w_txd_nx;
            r_busy  <= (w_state_nx != S_IDLE) || (w_lvl_nx != '0);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ovf   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_ovf_evt)        r_ovf <= 1'b1;
            else if (w_rd_status) r_ovf <= 1'b0;
            if (w_rd) r_rdata <= (w_off == UART_STATUS) ? w_status : '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: a timing model of the FIFO and
// frame schedule predicts bytes, frame start cycles, STATUS and tx_busy.
module tb_uart_tx_mmio;

    localparam int DIV   = 10;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * DIV;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        io_sel = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wmask = '0;
    logic        mem_rstrb = 1'b0;
    logic [31:0] mem_rdata;
    logic        TXD;
    logic        tx_busy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct { int t_wr; int t_start; logic [7:0] data; } rec_t;
    typedef struct { logic [7:0] data; int start; } tx_exp_t;
    typedef struct { int t; logic [31:0] v; } rd_exp_t;

    rec_t        recs[$];
    tx_exp_t     sb[$];
    rd_exp_t     rdq[$];
    logic        m_ovf = 1'b0;
    int          last_end = 0;
    logic [31:0] rd_hold = '0;

    uart_tx_mmio #(
        .CLK_FREQ_HZ (1_000_000),
        .BAUD        (100_000),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .io_sel    (io_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .TXD       (TXD),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Bytes accepted by edge t and not yet handed to the transmitter
    function automatic int level_after(input int t);
        int n = 0;
        foreach (recs[i])
            if (recs[i].t_wr <= t && recs[i].t_start > t) n++;
        return n;
    endfunction

    function automatic bit active_after(input int t);
        foreach (recs[i])
            if (recs[i].t_start <= t && t < recs[i].t_start + FRAME)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic int pops_at(input int t);
        int n = 0;
        foreach (recs[i]) if (recs[i].t_start == t) n++;
        return n;
    endfunction

    function automatic logic [31:0] status_at(input int t);
        logic [31:0] lv;
        lv = level_after(t - 1);
        return {23'd0, lv[4:0], m_ovf, active_after(t - 1),
                lv == 0, lv == DEPTH};
    endfunction

    task automatic bus(input logic sel, input logic [1:0] off,
                       input logic [31:0] wd, input logic [3:0] wm,
                       input logic rs);
        int t, lvl, st;
        bit rej;
        @(negedge clk);
        t = cyc + 1;
        io_sel    = sel;
        mem_addr  = {$urandom_range(0, 255), off, 2'($urandom_range(0, 3))};
        mem_addr[31:4] = 28'($urandom);
        mem_wdata = wd;
        mem_wmask = wm;
        mem_rstrb = rs;
        rej = 1'b0;
        if (sel && rs)
            rdq.push_back('{t, (off == 2'd1) ? status_at(t) : 32'd0});
        if (sel && off == 2'd0 && wm[0]) begin
            lvl = level_after(t - 1) - pops_at(t);
            if (lvl < DEPTH) begin
                st = (t + 1 > last_end) ? t + 1 : last_end;
                recs.push_back('{t, st, wd[7:0]});
                sb.push_back('{wd[7:0], st});
                last_end = st + FRAME;
            end else begin
                rej = 1'b1;
                m_ovf = 1'b1;
            end
        end
        if (sel && rs && off == 2'd1 && !rej) m_ovf = 1'b0;
    endtask

    task automatic idle_bus();
        bus(1'b0, 2'd0, 32'd0, 4'd0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || tx_busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_within_budget", 32'(n < 5000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic midframe_reset();
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("reset_txd", {31'd0, TXD}, 32'd1);
        check("reset_busy", {31'd0, tx_busy}, 32'd0);
        check("reset_rdata", mem_rdata, 32'd0);
        recs.delete();
        sb.delete();
        rdq.delete();
        m_ovf = 1'b0;
        last_end = 0;
        rd_hold = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 resetn = 1'b1;
    endtask

    // TXD monitor: captures whole frames and compares against the scoreboard
    initial begin
        logic       wav [FRAME];
        logic [9:0] fr;
        logic [7:0] got;
        int         t0, bad;
        bit         abort;
        tx_exp_t    e;
        forever begin
            @(negedge clk);
            if (resetn && TXD === 1'b0) begin
                t0 = cyc;
                abort = 1'b0;
                wav[0] = TXD;
                for (int j = 1; j < FRAME; j++) begin
                    @(negedge clk);
                    if (!resetn) begin
                        abort = 1'b1;
                        break;
                    end
                    wav[j] = TXD;
                end
                if (!abort) begin
                    for (int k = 0; k < 8; k++)
                        got[k] = wav[(k + 1) * DIV + DIV / 2];
                    if (sb.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_frame: got byte %h at cycle %0d, required none",
                                 got, t0);
                    end else begin
                        e = sb.pop_front();
                        fr = {1'b1, e.data, 1'b0};
                        bad = 0;
                        for (int j = 0; j < FRAME; j++)
                            if (wav[j] !== fr[j / DIV]) bad++;
                        check("tx_byte", {24'd0, got}, {24'd0, e.data});
                        check("tx_start_cycle", t0, e.start);
                        check("tx_wave_errors", bad, 0);
                    end
                end
            end
        end
    end

    // Per-cycle monitor for read data and tx_busy
    initial begin
        rd_exp_t r;
        logic    exp_busy;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (rdq.size() != 0 && rdq[0].t == cyc) begin
                    r = rdq.pop_front();
                    rd_hold = r.v;
                end
                check("mem_rdata", mem_rdata, rd_hold);
                exp_busy = active_after(cyc) || (level_after(cyc) > 0);
                check("tx_busy", {31'd0, tx_busy}, {31'd0, exp_busy});
            end
        end
    end

    initial begin
        #500_000;
        fails++;
        $display("FAIL global_timeout: cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

    initial begin
        int kind;
        repeat (3) @(posedge clk);
        #1;
        check("por_txd", {31'd0, TXD}, 32'd1);
        check("por_busy", {31'd0, tx_busy}, 32'd0);
        check("por_rdata", mem_rdata, 32'd0);
        @(negedge clk);
        #2 resetn = 1'b1;

        // Idle STATUS after reset
        bus(1'b1, 2'd1, 32'd0, 4'd0, 1'b1);
        idle_bus();
        repeat (4) @(negedge clk);

        // Single byte
        bus(1'b1, 2'd0, 32'h55, 4'h1, 1'b0);
        idle_bus();
        drain();

        // Two bytes back to back
        bus(1'b1, 2'd0, 32'hA5, 4'h1, 1'b0);
        bus(1'b1, 2'd0, 32'h3C, 4'hF, 1'b0);
        idle_bus();
        drain();

        // Overflow: six consecutive writes, then two STATUS reads
        for (int i = 1; i <= 6; i++)
            bus(1'b1, 2'd0, 32'(i), 4'h1, 1'b0);
        bus(1'b1, 2'd1, 32'd0, 4'd0, 1'b1);
        bus(1'b1, 2'd1, 32'd0, 4'd0, 1'b1);
        idle_bus();
        drain();

        // Reset during the data bits with a second byte queued
        bus(1'b1, 2'd0, 32'h55, 4'h1, 1'b0);
        bus(1'b1, 2'd0, 32'h77, 4'h1, 1'b0);
        idle_bus();
        repeat (45) @(negedge clk);
        midframe_reset();
        bus(1'b1, 2'd1, 32'd0, 4'd0, 1'b1);
        idle_bus();
        repeat (150) @(negedge clk);

        // Unused offsets and ignored writes
        bus(1'b1, 2'd1, 32'd0, 4'd0, 1'b1);
        bus(1'b1, 2'd0, 32'd0, 4'd0, 1'b1);
        bus(1'b1, 2'd1, 32'd0, 4'd0, 1'b1);
        bus(1'b1, 2'd2, 32'd0, 4'd0, 1'b1);
        bus(1'b1, 2'd1, 32'hFF, 4'hF, 1'b0);
        bus(1'b1, 2'd2, 32'hEE, 4'hF, 1'b0);
        bus(1'b0, 2'd0, 32'hDD, 4'hF, 1'b0);
        bus(1'b1, 2'd0, 32'hCC, 4'hE, 1'b0);
        bus(1'b1, 2'd1, 32'd0, 4'd0, 1'b1);
        bus(1'b1, 2'd3, 32'd0, 4'd0, 1'b1);
        idle_bus();
        repeat (120) @(negedge clk);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            kind = $urandom_range(0, 19);
            if (kind < 3)
                bus(($urandom_range(0, 9) != 0), 2'd0, $urandom,
                    4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
            else if (kind < 5)
                bus(1'b1, 2'($urandom_range(0, 3)), $urandom,
                    4'($urandom), 1'b0);
            else if (kind < 8)
                bus(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                    32'd0, 4'd0, 1'b1);
            else
                idle_bus();
        end
        idle_bus();
        drain();
        check("scoreboard_empty", sb.size(), 0);
        check("read_queue_empty", rdq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
